// File: rtl/csr_lhs_encoder.sv
// csr_lhs_encoder: producer side of the SpMM/PE lhs CSR interface.
// Takes one dense N-wide row per cycle, packs its nonzeros in ascending
// column order into an N-slot CSR beat and holds each closed beat until
// lhs_ready. When a row overflows the beat, the excess entries wait in a
// residual register and start the next beat.
// Optional feature macro: CSR_NNZ_CNT_EN adds the nnz_total output, the
// nonzero count of the last completed matrix.
module csr_lhs_encoder #(
  parameter int N = 16,
  parameter int W = 8,
  localparam int LGN   = $clog2(N),
  localparam int DBLGN = 2 * $clog2(N)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0][W-1:0]         in_row,
  input  logic                        in_last,
  input  logic                        lhs_ready,
  output logic                        lhs_start,
  output logic                        lhs_last,
  output logic [N-1:0][DBLGN-1:0]     lhs_ptr,
  output logic [N-1:0][LGN-1:0]       lhs_col,
  output logic [N-1:0][W-1:0]         lhs_data
`ifdef CSR_NNZ_CNT_EN
  ,
  output logic [DBLGN:0]              nnz_total
`endif
);

  // Fill counts 0..N; a packing slot can reach up to 2N-1.
  localparam int FW = LGN + 1;
  localparam int SW = LGN + 2;

  typedef enum logic [1:0] {ST_ACCEPT, ST_HOLD, ST_SPILL} state_t;

  state_t state, state_nxt;

  logic [FW-1:0]              fill;
  logic [LGN-1:0]             row_cnt;

  // Residual entries of an overflowing row, plus where they belong.
  logic [N-1:0][LGN-1:0]      res_col;
  logic [N-1:0][W-1:0]        res_data;
  logic [FW-1:0]              res_cnt;
  logic [LGN-1:0]             res_row;
  logic                       res_end;

  // Candidate beat after packing the incoming row.
  logic [N-1:0][DBLGN-1:0]    pk_ptr;
  logic [N-1:0][LGN-1:0]      pk_col;
  logic [N-1:0][W-1:0]        pk_data;
  logic [FW-1:0]              pk_fill;
  logic [N-1:0][LGN-1:0]      rs_col;
  logic [N-1:0][W-1:0]        rs_data;
  logic [FW-1:0]              rs_cnt;
  logic [SW-1:0]              slot;
  logic [SW-1:0]              rs_idx;
  logic                       overflow;

  // Beat rebuilt from the residual register.
  logic [N-1:0][DBLGN-1:0]    rl_ptr;

  logic                       accept;
  logic                       row_end;
  logic                       close;

  assign accept  = in_valid & in_ready;
  assign row_end = in_last | (row_cnt == LGN'(N - 1));
  assign close   = (pk_fill == FW'(N)) | row_end;

  // Pack the incoming row's nonzeros after the current fill; spill the rest.
  always_comb begin
    pk_ptr  = lhs_ptr;
    pk_col  = lhs_col;
    pk_data = lhs_data;
    rs_col  = '0;
    rs_data = '0;
    rs_idx  = '0;
    slot    = SW'(fill);
    for (int c = 0; c < N; c++) begin
      if (in_row[c] != '0) begin
        if (slot < SW'(N)) begin
          pk_col[slot[LGN-1:0]]  = LGN'(c);
          pk_data[slot[LGN-1:0]] = in_row[c];
        end else begin
          rs_idx                  = slot - SW'(N);
          rs_col[rs_idx[LGN-1:0]]  = LGN'(c);
          rs_data[rs_idx[LGN-1:0]] = in_row[c];
        end
        slot = slot + 1'b1;
      end
    end
    overflow = (slot > SW'(N));
    pk_fill  = overflow ? FW'(N) : slot[FW-1:0];
    rs_cnt   = overflow ? FW'(slot - SW'(N)) : '0;
    for (int i = 0; i < N; i++) begin
      if (LGN'(i) >= row_cnt) pk_ptr[i] = DBLGN'(pk_fill);
    end
  end

  // Row pointers of a beat that starts with the residual of row res_row.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rl_ptr[i] = (LGN'(i) >= res_row) ? DBLGN'(res_cnt) : '0;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_ACCEPT;
    else       state <= state_nxt;
  end

  // Next-state: close a beat on accept, release it on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCEPT: if (accept && close) state_nxt = overflow ? ST_SPILL : ST_HOLD;
      ST_HOLD:   if (lhs_ready)       state_nxt = ST_ACCEPT;
      ST_SPILL:  if (lhs_ready)       state_nxt = res_end ? ST_HOLD : ST_ACCEPT;
      default:                        state_nxt = ST_ACCEPT;
    endcase
  end

  // Handshake outputs: rows accepted only when no beat is pending.
  always_comb begin
    in_ready  = (state == ST_ACCEPT);
    lhs_start = (state != ST_ACCEPT) & lhs_ready;
  end

  // Beat buffer, fill, row counter and residual register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lhs_ptr  <= '0;
      lhs_col  <= '0;
      lhs_data <= '0;
      lhs_last <= 1'b0;
      fill     <= '0;
      row_cnt  <= '0;
      res_col  <= '0;
      res_data <= '0;
      res_cnt  <= '0;
      res_row  <= '0;
      res_end  <= 1'b0;
    end else if (accept) begin
      lhs_ptr  <= pk_ptr;
      lhs_col  <= pk_col;
      lhs_data <= pk_data;
      fill     <= pk_fill;
      lhs_last <= row_end & ~overflow;
      row_cnt  <= row_end ? '0 : row_cnt + 1'b1;
      if (overflow) begin
        res_col  <= rs_col;
        res_data <= rs_data;
        res_cnt  <= rs_cnt;
        res_row  <= row_cnt;
        res_end  <= row_end;
      end
    end else if (lhs_start && state == ST_SPILL) begin
      lhs_ptr  <= rl_ptr;
      lhs_col  <= res_col;
      lhs_data <= res_data;
      fill     <= res_cnt;
      lhs_last <= res_end;
      res_col  <= '0;
      res_data <= '0;
      res_cnt  <= '0;
      res_end  <= 1'b0;
    end else if (lhs_start) begin
      lhs_ptr  <= '0;
      lhs_col  <= '0;
      lhs_data <= '0;
      fill     <= '0;
      lhs_last <= 1'b0;
    end
  end

`ifdef CSR_NNZ_CNT_EN
  logic [DBLGN:0] nnz_acc;
  logic [SW-1:0]  row_nnz;

  assign row_nnz = slot - SW'(fill);

  // Accumulate per-matrix nonzeros; publish on the final-beat handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nnz_acc   <= '0;
      nnz_total <= '0;
    end else if (accept) begin
      nnz_acc <= nnz_acc + (DBLGN + 1)'(row_nnz);
    end else if (lhs_start && lhs_last) begin
      nnz_total <= nnz_acc;
      nnz_acc   <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_csr_lhs_encoder.sv
// Bench for csr_lhs_encoder (N=4, W=8): directed matrices plus random
// matrices checked against a CSR beat model built from the nonzero stream.
module tb_csr_lhs_encoder;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LG = $clog2(N);
  localparam int DB = 2 * $clog2(N);

  typedef logic [N-1:0][W-1:0]  row_t;
  typedef logic [N-1:0][DB-1:0] ptr_t;
  typedef logic [N-1:0][LG-1:0] col_t;
  typedef struct {
    ptr_t ptr;
    col_t col;
    row_t data;
    logic last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  row_t in_row;
  logic in_last;
  logic lhs_ready;
  logic lhs_start;
  logic lhs_last;
  ptr_t lhs_ptr;
  col_t lhs_col;
  row_t lhs_data;

  int checks   = 0;
  int failures = 0;

  row_t  mat [N];
  beat_t exp_q[$];
  beat_t obs_q[$];

  always #5 clk = ~clk;

  csr_lhs_encoder #(.N(N), .W(W)) dut (
    .clock     (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_last   (in_last),
    .lhs_ready (lhs_ready),
    .lhs_start (lhs_start),
    .lhs_last  (lhs_last),
    .lhs_ptr   (lhs_ptr),
    .lhs_col   (lhs_col),
    .lhs_data  (lhs_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic row_t mkrow(input int a, input int b, input int c, input int d);
    row_t r;
    r[0] = W'(a); r[1] = W'(b); r[2] = W'(c); r[3] = W'(d);
    return r;
  endfunction

  function automatic ptr_t mkptr(input int a, input int b, input int c, input int d);
    ptr_t p;
    p[0] = DB'(a); p[1] = DB'(b); p[2] = DB'(c); p[3] = DB'(d);
    return p;
  endfunction

  function automatic col_t mkcol(input int a, input int b, input int c, input int d);
    col_t p;
    p[0] = LG'(a); p[1] = LG'(b); p[2] = LG'(c); p[3] = LG'(d);
    return p;
  endfunction

  // Reference: the matrix's nonzeros in row-major order, cut into chunks of N;
  // the last chunk may be short, and an empty matrix still yields one beat.
  // ptr[i] = number of entries in the beat whose row is <= i.
  task automatic build_model(input int nrows);
    int er[$];
    int ec[$];
    int ev[$];
    int n;
    int nb;
    int idx;
    int cnt;
    beat_t b;
    exp_q.delete();
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < N; c++)
        if (mat[r][c] != 0) begin
          er.push_back(r); ec.push_back(c); ev.push_back(int'(mat[r][c]));
        end
    n  = er.size();
    nb = (n + N - 1) / N;
    if (nb == 0) nb = 1;
    for (int bi = 0; bi < nb; bi++) begin
      b.ptr = '0; b.col = '0; b.data = '0;
      b.last = (bi == nb - 1);
      for (int s = 0; s < N; s++) begin
        idx = bi * N + s;
        if (idx < n) begin
          b.col[s]  = LG'(ec[idx]);
          b.data[s] = W'(ev[idx]);
        end
      end
      for (int i = 0; i < N; i++) begin
        cnt = 0;
        for (int s = 0; s < N; s++) begin
          idx = bi * N + s;
          if (idx < n && er[idx] <= i) cnt++;
        end
        b.ptr[i] = DB'(cnt);
      end
      exp_q.push_back(b);
    end
  endtask

  // Stream mat[0..nrows-1] in with random valid/ready and score every beat.
  task automatic run_matrix(input int nrows, input bit endflag, input int vpct, input int rpct);
    int ri  = 0;
    int bi  = 0;
    int cyc = 0;
    bit done = 1'b0;
    beat_t ob;
    build_model(nrows);
    obs_q.delete();
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      in_valid = (ri < nrows) && ($urandom_range(99, 0) < vpct);
      if (ri < nrows) in_row = mat[ri];
      else            in_row = '0;
      in_last   = (ri == nrows - 1) && (endflag || nrows < N);
      lhs_ready = ($urandom_range(99, 0) < rpct);
      @(negedge clk);
      if (in_valid && in_ready) ri++;
      if (lhs_start) begin
        ob.ptr = lhs_ptr; ob.col = lhs_col; ob.data = lhs_data; ob.last = lhs_last;
        obs_q.push_back(ob);
        if (bi < exp_q.size()) begin
          chk("beat_ptr",  lhs_ptr,  exp_q[bi].ptr);
          chk("beat_col",  lhs_col,  exp_q[bi].col);
          chk("beat_data", lhs_data, exp_q[bi].data);
          chk("beat_last", lhs_last, exp_q[bi].last);
        end else begin
          chk("beat_count", bi, exp_q.size());
        end
        bi++;
        if (bi >= exp_q.size()) done = 1'b1;
      end
      cyc++;
    end
    chk("matrix_timeout", done, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; lhs_ready = 1'b1;
    @(negedge clk);
    chk("no_extra_beat", lhs_start, 1'b0);
    chk("ready_after",   in_ready,  1'b1);
    chk("rows_taken",    ri,        nrows);
    lhs_ready = 1'b0;
  endtask

  // Present one row and hold it until accepted (bounded).
  task automatic drive_row(input row_t r, input logic last);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_row = r; in_last = last;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk); n++;
    end
    chk("drive_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_row = '0; in_last = 1'b0; lhs_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready,  1'b1);
    chk("rst_start",    lhs_start, 1'b0);
    chk("rst_last",     lhs_last,  1'b0);
    chk("rst_ptr",      lhs_ptr,   '0);
    chk("rst_col",      lhs_col,   '0);
    chk("rst_data",     lhs_data,  '0);
    reset = 1'b0;

    // Spill across two beats.
    mat[0] = mkrow(1, 0, 2, 0); mat[1] = mkrow(0, 0, 0, 0);
    mat[2] = mkrow(0, 3, 0, 0); mat[3] = mkrow(4, 5, 6, 7);
    run_matrix(4, 1'b1, 100, 100);
    chk("t1_nbeats", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("t1_b1_ptr",  obs_q[0].ptr,  mkptr(2, 2, 3, 4));
      chk("t1_b1_col",  obs_q[0].col,  mkcol(0, 2, 1, 0));
      chk("t1_b1_data", obs_q[0].data, mkrow(1, 2, 3, 4));
      chk("t1_b1_last", obs_q[0].last, 1'b0);
      chk("t1_b2_ptr",  obs_q[1].ptr,  mkptr(0, 0, 0, 3));
      chk("t1_b2_col",  obs_q[1].col,  mkcol(1, 2, 3, 0));
      chk("t1_b2_data", obs_q[1].data, mkrow(5, 6, 7, 0));
      chk("t1_b2_last", obs_q[1].last, 1'b1);
    end

    // All-zero matrix.
    for (int r = 0; r < N; r++) mat[r] = '0;
    run_matrix(4, 1'b0, 100, 100);
    chk("t2_nbeats", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      chk("t2_ptr",  obs_q[0].ptr,  '0);
      chk("t2_data", obs_q[0].data, '0);
      chk("t2_last", obs_q[0].last, 1'b1);
    end

    // Exact fit at matrix end.
    mat[0] = mkrow(5, 0, 0, 0); mat[1] = mkrow(0, 6, 0, 0);
    mat[2] = mkrow(0, 0, 7, 0); mat[3] = mkrow(0, 0, 0, 8);
    run_matrix(4, 1'b0, 100, 100);
    chk("t3_nbeats", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      chk("t3_ptr",  obs_q[0].ptr,  mkptr(1, 2, 3, 4));
      chk("t3_col",  obs_q[0].col,  mkcol(0, 1, 2, 3));
      chk("t3_data", obs_q[0].data, mkrow(5, 6, 7, 8));
      chk("t3_last", obs_q[0].last, 1'b1);
    end

    // Early in_last with 5 cycles of backpressure, then a fresh row 0.
    lhs_ready = 1'b0;
    drive_row(mkrow(9, 0, 0, 0), 1'b0);
    drive_row(mkrow(0, 0, 0, 8), 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_start", lhs_start, 1'b0);
      chk("bp_ready", in_ready,  1'b0);
      chk("bp_ptr",   lhs_ptr,   mkptr(1, 2, 2, 2));
      chk("bp_col",   lhs_col,   mkcol(0, 3, 0, 0));
      chk("bp_data",  lhs_data,  mkrow(9, 8, 0, 0));
      chk("bp_last",  lhs_last,  1'b1);
    end
    @(posedge clk); #1; lhs_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_start", lhs_start, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_single_start", lhs_start, 1'b0);
    chk("bp_ready_back",   in_ready,  1'b1);
    lhs_ready = 1'b0;
    drive_row(mkrow(0, 3, 0, 0), 1'b1);
    @(negedge clk);
    chk("row0_ptr",  lhs_ptr,  mkptr(1, 1, 1, 1));
    chk("row0_col",  lhs_col,  mkcol(1, 0, 0, 0));
    chk("row0_data", lhs_data, mkrow(3, 0, 0, 0));
    chk("row0_last", lhs_last, 1'b1);
    @(posedge clk); #1; lhs_ready = 1'b1;
    @(negedge clk);
    chk("row0_start", lhs_start, 1'b1);
    @(posedge clk); #1; lhs_ready = 1'b0;

    // Random matrices.
    for (int t = 0; t < 40; t++) begin
      int nr;
      int dens;
      nr   = $urandom_range(N, 1);
      dens = $urandom_range(100, 0);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mat[r][c] = ($urandom_range(99, 0) < dens) ? W'($urandom_range(255, 1)) : '0;
      run_matrix(nr, ($urandom_range(1, 0) == 1), $urandom_range(100, 50), $urandom_range(100, 30));
    end

    // Reset while a spilled beat is pending.
    lhs_ready = 1'b0;
    drive_row(mkrow(1, 0, 2, 0), 1'b0);
    drive_row(mkrow(0, 0, 0, 0), 1'b0);
    drive_row(mkrow(0, 3, 0, 0), 1'b0);
    drive_row(mkrow(4, 5, 6, 7), 1'b1);
    @(negedge clk);
    lhs_ready = 1'b1;
    #1;
    chk("spill_pending", lhs_start, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("spill_rst_start", lhs_start, 1'b0);
    chk("spill_rst_ready", in_ready,  1'b1);
    chk("spill_rst_ptr",   lhs_ptr,   '0);
    lhs_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_ready", in_ready, 1'b1);
    mat[0] = mkrow(5, 0, 0, 0); mat[1] = mkrow(0, 6, 0, 0);
    mat[2] = mkrow(0, 0, 7, 0); mat[3] = mkrow(0, 0, 0, 8);
    run_matrix(4, 1'b1, 80, 60);
    chk("post_rst_nbeats", obs_q.size(), 1);
    if (obs_q.size() >= 1) chk("post_rst_ptr", obs_q[0].ptr, mkptr(1, 2, 3, 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
